// File: rtl/d_queue_decode_pkg.sv
// Shared decode definitions for the queued decode stage:
// opcodes, ALU control groups, immediate formats and control flags.
package d_queue_decode_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  localparam logic [5:0] ALU_NONE  = 6'd0;
  localparam logic [2:0] ALU_BR    = 3'b010;

  typedef enum logic [2:0] {
    IMM_NONE,
    IMM_I,
    IMM_S,
    IMM_B,
    IMM_U,
    IMM_J
  } imm_fmt_e;

  typedef struct packed {
    logic is_wb;
    logic is_load;
    logic is_store;
    logic is_branch;
    logic is_jump;
    logic is_imm;
    logic illegal;
  } ctrl_t;

  function automatic logic [31:0] imm32(
    input imm_fmt_e    f,
    input logic [31:0] i
  );
    logic [31:0] r;
    case (f)
      IMM_I:   r = {{20{i[31]}}, i[31:20]};
      IMM_S:   r = {{20{i[31]}}, i[31:25], i[11:7]};
      IMM_B:   r = {{19{i[31]}}, i[31], i[7],
                    i[30:25], i[11:8], 1'b0};
      IMM_U:   r = {i[31:12], 12'd0};
      IMM_J:   r = {{11{i[31]}}, i[31], i[19:12],
                    i[20], i[30:21], 1'b0};
      default: r = 32'd0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/d_queue_decode_inst_queue.sv
// Instruction FIFO holding {pc, instr} pairs between fetch and decode.
// Flush clears every entry on the same edge.
module d_inst_queue
  import d_queue_decode_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            i_push,
  input  logic            i_pop,
  input  logic            i_flush,
  input  logic [XLEN-1:0] i_pc,
  input  logic [31:0]     i_instr,
  output logic [XLEN-1:0] o_pc,
  output logic [31:0]     o_instr,
  output logic            o_full,
  output logic            o_empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [XLEN-1:0] r_pc    [DEPTH];
  logic [31:0]     r_instr [DEPTH];
  logic [PW-1:0]   r_head;
  logic [PW-1:0]   r_tail;
  logic [CW-1:0]   r_count;
  logic            w_push;
  logic            w_pop;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign w_push  = i_push && !o_full && !i_flush;
  assign w_pop   = i_pop && !o_empty && !i_flush;
  assign o_pc    = r_pc[r_head];
  assign o_instr = r_instr[r_head];

  always_ff @(posedge clock) begin
    if (w_push) begin
      r_pc[r_tail]    <= i_pc;
      r_instr[r_tail] <= i_instr;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (i_flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_tail <= nxt(r_tail);
      if (w_pop)  r_head <= nxt(r_head);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/d_queue_decode.sv
// Queued RV32I decode stage: FIFO head is decoded, bypassed from
// writeback, checked against the load-use scoreboard and registered.
module d_queue_decode
  import d_queue_decode_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int DEPTH    = 2,
  parameter int LOAD_LAT = 1
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            fd_valid,
  output logic            fd_ready,
  input  logic [XLEN-1:0] fd_pc,
  input  logic [31:0]     fd_instr,
  input  logic            flush,
  output logic [4:0]      rf_sel1,
  output logic [4:0]      rf_sel2,
  input  logic [XLEN-1:0] rf_data1,
  input  logic [XLEN-1:0] rf_data2,
  input  logic            wb_en,
  input  logic [4:0]      wb_sel,
  input  logic [XLEN-1:0] wb_data,
  output logic            da_valid,
  input  logic            da_ready,
  output logic [XLEN-1:0] da_pc,
  output logic [XLEN-1:0] da_imm,
  output logic [XLEN-1:0] da_target_pc,
  output logic [XLEN-1:0] da_data1,
  output logic [XLEN-1:0] da_data2,
  output logic [4:0]      da_rs1,
  output logic [4:0]      da_rs2,
  output logic [4:0]      da_rd,
  output logic [5:0]      da_alu_ctrl,
  output logic            da_is_wb,
  output logic            da_is_load,
  output logic            da_is_store,
  output logic            da_is_branch,
  output logic            da_is_jump,
  output logic            da_is_imm,
  output logic            da_illegal,
  output logic            hazard_stall
);

  localparam int CNTW = $clog2(LOAD_LAT + 1);

  logic [XLEN-1:0] w_pc;
  logic [31:0]     w_instr;
  logic            w_full;
  logic            w_empty;
  logic            w_push;
  logic            w_issue;
  logic [6:0]      w_op;
  logic [2:0]      w_f3;
  logic [4:0]      w_rs1;
  logic [4:0]      w_rs2;
  logic [4:0]      w_rd;
  imm_fmt_e        w_fmt;
  ctrl_t           w_ctl;
  logic [5:0]      w_alu;
  logic [XLEN-1:0] w_imm;
  logic [XLEN-1:0] w_tgt;
  logic [XLEN-1:0] w_op1;
  logic [XLEN-1:0] w_op2;
  logic            w_use1;
  logic            w_use2;
  logic            w_hazard;

  logic [CNTW-1:0] r_ld_cnt;
  logic [4:0]      r_pend_rd;
  logic            r_valid;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_imm;
  logic [XLEN-1:0] r_tgt;
  logic [XLEN-1:0] r_d1;
  logic [XLEN-1:0] r_d2;
  logic [4:0]      r_rs1;
  logic [4:0]      r_rs2;
  logic [4:0]      r_rd;
  logic [5:0]      r_alu;
  ctrl_t           r_ctl;

  assign fd_ready = !reset && !w_full;
  assign w_push   = fd_valid && fd_ready && !flush;

  d_inst_queue #(
    .XLEN  (XLEN),
    .DEPTH (DEPTH)
  ) u_q (
    .clock   (clock),
    .reset   (reset),
    .i_push  (w_push),
    .i_pop   (w_issue),
    .i_flush (flush),
    .i_pc    (fd_pc),
    .i_instr (fd_instr),
    .o_pc    (w_pc),
    .o_instr (w_instr),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign w_op    = w_instr[6:0];
  assign w_f3    = w_instr[14:12];
  assign w_rs1   = w_instr[19:15];
  assign w_rs2   = w_instr[24:20];
  assign w_rd    = w_instr[11:7];
  assign rf_sel1 = w_rs1;
  assign rf_sel2 = w_rs2;

  always_comb begin
    w_fmt = IMM_NONE;
    w_ctl = '0;
    w_alu = ALU_NONE;
    unique case (w_op)
      OP_R: begin
        w_ctl.is_wb = 1'b1;
        w_alu = {2'b00, w_instr[30], w_f3};
      end
      OP_IMM: begin
        w_ctl.is_wb  = 1'b1;
        w_ctl.is_imm = 1'b1;
        w_fmt = IMM_I;
        w_alu = {2'b00, w_instr[30] & (w_f3 == 3'b101), w_f3};
      end
      OP_LOAD: begin
        w_ctl.is_wb   = 1'b1;
        w_ctl.is_load = 1'b1;
        w_fmt = IMM_I;
      end
      OP_STORE: begin
        w_ctl.is_store = 1'b1;
        w_fmt = IMM_S;
      end
      OP_BRANCH: begin
        w_ctl.is_branch = 1'b1;
        w_fmt = IMM_B;
        w_alu = {ALU_BR, w_f3};
      end
      OP_JAL: begin
        w_ctl.is_wb   = 1'b1;
        w_ctl.is_jump = 1'b1;
        w_fmt = IMM_J;
      end
      OP_LUI: begin
        w_ctl.is_wb  = 1'b1;
        w_ctl.is_imm = 1'b1;
        w_fmt = IMM_U;
      end
      default: w_ctl.illegal = 1'b1;
    endcase
    w_ctl.is_wb = w_ctl.is_wb & (w_rd != 5'd0);
  end

  assign w_imm = XLEN'($signed(imm32(w_fmt, w_instr)));
  assign w_tgt = (w_ctl.is_branch || w_ctl.is_jump)
               ? w_pc + w_imm : '0;

  // Writeback data wins over the regfile read in the same cycle
  assign w_op1 = (wb_en && wb_sel == w_rs1 && wb_sel != 5'd0)
               ? wb_data : rf_data1;
  assign w_op2 = (wb_en && wb_sel == w_rs2 && wb_sel != 5'd0)
               ? wb_data : rf_data2;

  assign w_use1 = !(w_op == OP_JAL || w_op == OP_LUI);
  assign w_use2 = (w_op == OP_R) || (w_op == OP_STORE)
               || (w_op == OP_BRANCH);

  // A second load may not overwrite a still-busy pending rd
  assign w_hazard =
    ((r_ld_cnt != '0) && (r_pend_rd != 5'd0) &&
     ((w_use1 && w_rs1 == r_pend_rd) ||
      (w_use2 && w_rs2 == r_pend_rd)))
    || (w_ctl.is_load && (r_ld_cnt > CNTW'(1)));

  assign hazard_stall = w_hazard && !w_empty;
  assign w_issue = !w_empty && !w_hazard
                && (!r_valid || da_ready) && !flush;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_ld_cnt  <= '0;
      r_pend_rd <= '0;
    end else if (w_issue && w_ctl.is_load && w_rd != 5'd0) begin
      r_ld_cnt  <= CNTW'(LOAD_LAT);
      r_pend_rd <= w_rd;
    end else if (da_ready && r_ld_cnt != '0) begin
      r_ld_cnt  <= r_ld_cnt - CNTW'(1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_valid <= 1'b0;
      r_pc    <= '0;
      r_imm   <= '0;
      r_tgt   <= '0;
      r_d1    <= '0;
      r_d2    <= '0;
      r_rs1   <= '0;
      r_rs2   <= '0;
      r_rd    <= '0;
      r_alu   <= '0;
      r_ctl   <= '0;
    end else if (flush) begin
      r_valid <= 1'b0;
    end else if (w_issue) begin
      r_valid <= 1'b1;
      r_pc    <= w_pc;
      r_imm   <= w_imm;
      r_tgt   <= w_tgt;
      r_d1    <= w_op1;
      r_d2    <= w_op2;
      r_rs1   <= w_rs1;
      r_rs2   <= w_rs2;
      r_rd    <= w_rd;
      r_alu   <= w_alu;
      r_ctl   <= w_ctl;
    end else if (da_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign da_valid     = r_valid;
  assign da_pc        = r_pc;
  assign da_imm       = r_imm;
  assign da_target_pc = r_tgt;
  assign da_data1     = r_d1;
  assign da_data2     = r_d2;
  assign da_rs1       = r_rs1;
  assign da_rs2       = r_rs2;
  assign da_rd        = r_rd;
  assign da_alu_ctrl  = r_alu;
  assign da_is_wb     = r_ctl.is_wb;
  assign da_is_load   = r_ctl.is_load;
  assign da_is_store  = r_ctl.is_store;
  assign da_is_branch = r_ctl.is_branch;
  assign da_is_jump   = r_ctl.is_jump;
  assign da_is_imm    = r_ctl.is_imm;
  assign da_illegal   = r_ctl.illegal;

endmodule

// File: tb/tb_d_queue_decode.sv
// Scoreboard bench for d_queue_decode: directed instructions with
// hand-derived bundles, checked by a monitor on each da handshake.
module tb_d_queue_decode;

  localparam int XLEN     = 32;
  localparam int DEPTH    = 2;
  localparam int LOAD_LAT = 1;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        fd_valid = 1'b0;
  logic        fd_ready;
  logic [31:0] fd_pc = '0;
  logic [31:0] fd_instr = '0;
  logic        flush = 1'b0;
  logic [4:0]  rf_sel1, rf_sel2;
  logic [31:0] rf_data1, rf_data2;
  logic        wb_en = 1'b0;
  logic [4:0]  wb_sel = '0;
  logic [31:0] wb_data = '0;
  logic        da_valid;
  logic        da_ready = 1'b1;
  logic [31:0] da_pc, da_imm, da_target_pc, da_data1, da_data2;
  logic [4:0]  da_rs1, da_rs2, da_rd;
  logic [5:0]  da_alu_ctrl;
  logic        da_is_wb, da_is_load, da_is_store, da_is_branch;
  logic        da_is_jump, da_is_imm, da_illegal;
  logic        hazard_stall;

  logic [31:0] regs [32];

  assign rf_data1 = regs[rf_sel1];
  assign rf_data2 = regs[rf_sel2];

  always #5 clock = ~clock;

  d_queue_decode #(
    .XLEN     (XLEN),
    .DEPTH    (DEPTH),
    .LOAD_LAT (LOAD_LAT)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .fd_valid     (fd_valid),
    .fd_ready     (fd_ready),
    .fd_pc        (fd_pc),
    .fd_instr     (fd_instr),
    .flush        (flush),
    .rf_sel1      (rf_sel1),
    .rf_sel2      (rf_sel2),
    .rf_data1     (rf_data1),
    .rf_data2     (rf_data2),
    .wb_en        (wb_en),
    .wb_sel       (wb_sel),
    .wb_data      (wb_data),
    .da_valid     (da_valid),
    .da_ready     (da_ready),
    .da_pc        (da_pc),
    .da_imm       (da_imm),
    .da_target_pc (da_target_pc),
    .da_data1     (da_data1),
    .da_data2     (da_data2),
    .da_rs1       (da_rs1),
    .da_rs2       (da_rs2),
    .da_rd        (da_rd),
    .da_alu_ctrl  (da_alu_ctrl),
    .da_is_wb     (da_is_wb),
    .da_is_load   (da_is_load),
    .da_is_store  (da_is_store),
    .da_is_branch (da_is_branch),
    .da_is_jump   (da_is_jump),
    .da_is_imm    (da_is_imm),
    .da_illegal   (da_illegal),
    .hazard_stall (hazard_stall)
  );

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] imm;
    logic [31:0] tgt;
    logic [31:0] d1;
    logic [31:0] d2;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [5:0]  alu;
    logic [6:0]  fl;
  } exp_t;

  exp_t sb[$];
  exp_t mon_a, mon_e;
  int   n_chk = 0;
  int   n_pass = 0;
  int   stall_cnt = 0;

  function automatic exp_t mk(
    input logic [31:0] pc, imm, tgt, d1, d2,
    input logic [4:0]  rs1, rs2, rd,
    input logic [5:0]  alu,
    input logic [6:0]  fl
  );
    exp_t e;
    e = {pc, imm, tgt, d1, d2, rs1, rs2, rd, alu, fl};
    return e;
  endfunction

  task automatic check(input string name,
                       input logic [63:0] act,
                       input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic push(input logic [31:0] pc,
                      input logic [31:0] ins,
                      input exp_t e,
                      input bit track);
    int w;
    bit acc;
    w = 0;
    fd_valid = 1'b1;
    fd_pc    = pc;
    fd_instr = ins;
    do begin
      acc = fd_ready;
      @(posedge clock);
      #1;
      w++;
    end while (!acc && w < 200);
    fd_valid = 1'b0;
    if (!acc) begin
      n_chk++;
      $display("FAIL push_timeout pc=%h: got no fd_ready expected accept",
               pc);
    end else if (track) begin
      sb.push_back(e);
    end
  endtask

  // Monitor: one bundle is consumed per valid&&ready cycle
  initial begin
    forever begin
      @(negedge clock);
      if (hazard_stall) stall_cnt++;
      if (!reset && da_valid && da_ready) begin
        mon_a = {da_pc, da_imm, da_target_pc, da_data1, da_data2,
                 da_rs1, da_rs2, da_rd, da_alu_ctrl,
                 {da_is_wb, da_is_load, da_is_store, da_is_branch,
                  da_is_jump, da_is_imm, da_illegal}};
        n_chk++;
        if (sb.size() == 0) begin
          $display("FAIL unexpected_bundle: got pc=%h expected none",
                   da_pc);
        end else begin
          mon_e = sb.pop_front();
          if (mon_a === mon_e) n_pass++;
          else $display("FAIL bundle pc=%h: got %h expected %h",
                        mon_e.pc, mon_a, mon_e);
        end
      end
    end
  end

  initial begin
    int w;
    for (int i = 0; i < 32; i++) regs[i] = 32'(i) * 32'h100;
    regs[5] = 32'h0;
    #1 reset = 1'b1;
    #2;
    check("rst_da_valid", 64'(da_valid), 64'd0);
    check("rst_fd_ready", 64'(fd_ready), 64'd0);
    check("rst_hazard", 64'(hazard_stall), 64'd0);
    check("rst_da_pc", 64'(da_pc), 64'd0);
    tick(2);
    reset = 1'b0;
    tick(1);

    // addi x1,x0,5 : one-edge latency
    push(32'h0, 32'h00500093,
         mk(32'h0, 32'd5, 0, 0, 0, 0, 5, 1, 6'd0, 7'b1000010), 1);
    check("lat_valid_early", 64'(da_valid), 64'd0);
    tick(1);
    check("lat_valid", 64'(da_valid), 64'd1);
    check("lat_rd", 64'(da_rd), 64'd1);
    tick(2);

    // lw x2,0(x1) ; add x3,x2,x2
    stall_cnt = 0;
    push(32'h4, 32'h0000A103,
         mk(32'h4, 0, 0, 32'h100, 0, 1, 0, 2, 6'd0, 7'b1100000), 1);
    push(32'h8, 32'h002101B3,
         mk(32'h8, 0, 0, 32'h200, 32'h200, 2, 2, 3, 6'd0, 7'b1000000), 1);
    tick(6);
    check("load_use_stalls", 64'(stall_cnt), 64'(LOAD_LAT));

    // beq x0,x0,-8
    push(32'h100, 32'hFE000CE3,
         mk(32'h100, 32'hFFFFFFF8, 32'hF8, 0, 0, 0, 0, 25,
            6'b010000, 7'b0001000), 1);
    tick(3);

    // Back-pressure with a full queue
    da_ready = 1'b0;
    push(32'h200, 32'h123453B7,
         mk(32'h200, 32'h12345000, 0, 32'h800, 32'h300, 8, 3, 7,
            6'd0, 7'b1000010), 1);
    push(32'h204, 32'h010000EF,
         mk(32'h204, 32'h10, 32'h214, 0, 32'h1000, 0, 16, 1,
            6'd0, 7'b1000100), 1);
    push(32'h208, 32'h0030A223,
         mk(32'h208, 32'd4, 0, 32'h100, 32'h300, 1, 3, 4,
            6'd0, 7'b0010000), 1);
    tick(1);
    check("full_fd_ready", 64'(fd_ready), 64'd0);
    check("full_da_valid", 64'(da_valid), 64'd1);
    fork
      push(32'h20C, 32'h4030D493,
           mk(32'h20C, 32'h403, 0, 32'h100, 32'h300, 1, 3, 9,
              6'b001101, 7'b1000010), 1);
      begin
        tick(3);
        check("hold_da_pc", 64'(da_pc), 64'h200);
        da_ready = 1'b1;
      end
    join
    tick(6);

    // Flush with full queue and a held bundle
    da_ready = 1'b0;
    for (int k = 0; k < 3; k++)
      push(32'h600 + 32'(k * 4), 32'h00500093, '0, 0);
    tick(1);
    check("pre_flush_fd_ready", 64'(fd_ready), 64'd0);
    check("pre_flush_valid", 64'(da_valid), 64'd1);
    flush = 1'b1;
    tick(1);
    flush = 1'b0;
    check("flush_da_valid", 64'(da_valid), 64'd0);
    check("flush_fd_ready", 64'(fd_ready), 64'd1);
    da_ready = 1'b1;
    push(32'h300, 32'hFFF00513,
         mk(32'h300, 32'hFFFFFFFF, 0, 0, 32'h1F00, 0, 31, 10,
            6'd0, 7'b1000010), 1);
    tick(1);
    check("post_flush_issue", 64'(da_valid), 64'd1);
    tick(3);

    // Writeback bypass, then x0 never bypasses
    wb_en = 1'b1; wb_sel = 5'd5; wb_data = 32'hDEAD;
    push(32'h400, 32'h00028333,
         mk(32'h400, 0, 0, 32'hDEAD, 0, 5, 0, 6, 6'd0, 7'b1000000), 1);
    tick(2);
    wb_en = 1'b0;
    tick(2);
    regs[5] = 32'h55;
    wb_en = 1'b1; wb_sel = 5'd0;
    push(32'h404, 32'h00028333,
         mk(32'h404, 0, 0, 32'h55, 0, 5, 0, 6, 6'd0, 7'b1000000), 1);
    tick(2);
    wb_en = 1'b0;
    tick(2);

    // Illegal opcode with rd=6
    push(32'h500, 32'h0000037F,
         mk(32'h500, 0, 0, 0, 0, 0, 0, 6, 6'd0, 7'b0000001), 1);
    w = 0;
    while (sb.size() != 0 && w < 100) begin
      tick(1);
      w++;
    end
    check("sb_drained", 64'(sb.size()), 64'd0);

    // Reset in the middle of traffic
    da_ready = 1'b0;
    push(32'h700, 32'h00500093, '0, 0);
    tick(1);
    check("pre_rst_valid", 64'(da_valid), 64'd1);
    #2 reset = 1'b1;
    #1;
    check("mid_rst_valid", 64'(da_valid), 64'd0);
    check("mid_rst_fd_ready", 64'(fd_ready), 64'd0);
    tick(2);
    reset = 1'b0;
    tick(2);
    check("post_rst_valid", 64'(da_valid), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
